// File: rtl/jtag_chain_master.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_chain_master
//  Purpose  : JTAG initiator; one IR scan + DR scan per start, returns captured TDO.
//             Optional macro JTAG_MASTER_TLR_EN prefixes each transaction with a TLR walk.
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_chain_master #(
    parameter int MAX_LEN = 32,
    parameter int TCK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [5:0]         ir_len_i,
    input  logic [MAX_LEN-1:0] ir_data_i,
    input  logic [5:0]         dr_len_i,
    input  logic [MAX_LEN-1:0] dr_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [MAX_LEN-1:0] dr_data_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    localparam int               DIV_W      = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [5:0]       C_MAX_LEN6 = 6'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
`ifdef JTAG_MASTER_TLR_EN
        S_TLR      = 4'd1,
`endif
        S_IR_HDR   = 4'd2,
        S_IR_SHIFT = 4'd3,
        S_IR_UPD   = 4'd4,
        S_DR_HDR   = 4'd5,
        S_DR_SHIFT = 4'd6,
        S_DR_TAIL  = 4'd7,
        S_FIN      = 4'd8
    } state_t;

`ifdef JTAG_MASTER_TLR_EN
    localparam state_t C_FIRST = S_TLR;
`else
    localparam state_t C_FIRST = S_IR_HDR;
`endif

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [5:0]         r_ir_len;
    logic [5:0]         r_dr_len;
    logic [MAX_LEN-1:0] r_ir;
    logic [MAX_LEN-1:0] r_dr;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_dout;
    logic               r_tdo_s1;
    logic               r_tdo_s2;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_busy;
    logic               r_done;

    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    state_t             w_nstate;
    logic [5:0]         w_ncnt;
    logic               w_ntms;
    logic               w_ntdi;
    logic [MAX_LEN-1:0] w_ir_nxt;
    logic [MAX_LEN-1:0] w_dr_nxt;
    logic [5:0]         w_ir_len_eff;
    logic [5:0]         w_dr_len_eff;
    logic [MAX_LEN-1:0] w_cap_aligned;

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign dr_data_o = r_dout;
    assign tck_o     = r_tck;
    assign tms_o     = r_tms;
    assign tdi_o     = r_tdi;

    assign w_tick = (r_div == C_DIV_LAST);
    assign w_rise = w_tick && !r_tck;
    assign w_fall = w_tick && r_tck;

    assign w_ir_len_eff = (ir_len_i == 6'd0) ? 6'd1 : ir_len_i;
    assign w_dr_len_eff = (dr_len_i == 6'd0)      ? 6'd1 :
                          (dr_len_i > C_MAX_LEN6) ? C_MAX_LEN6 : dr_len_i;

    // Captured bits enter at the MSB; shifting down by the unused width right-aligns them.
    assign w_cap_aligned = r_cap >> (MAX_LEN - int'(r_dr_len));

    // Next TCK step, evaluated for use at the falling edge of TCK.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt + 6'd1;
        w_ir_nxt = r_ir;
        w_dr_nxt = r_dr;
        case (r_state)
`ifdef JTAG_MASTER_TLR_EN
            S_TLR: begin
                if (r_cnt == 6'd5) begin
                    w_nstate = S_IR_HDR;
                    w_ncnt   = 6'd0;
                end
            end
`endif
            S_IR_HDR: begin
                if (r_cnt == 6'd3) begin
                    w_nstate = S_IR_SHIFT;
                    w_ncnt   = 6'd0;
                end
            end
            S_IR_SHIFT: begin
                w_ir_nxt = r_ir >> 1;
                if (r_cnt == r_ir_len - 6'd1) begin
                    w_nstate = S_IR_UPD;
                    w_ncnt   = 6'd0;
                end
            end
            S_IR_UPD: begin
                w_nstate = S_DR_HDR;
                w_ncnt   = 6'd0;
            end
            S_DR_HDR: begin
                if (r_cnt == 6'd2) begin
                    w_nstate = S_DR_SHIFT;
                    w_ncnt   = 6'd0;
                end
            end
            S_DR_SHIFT: begin
                w_dr_nxt = r_dr >> 1;
                if (r_cnt == r_dr_len - 6'd1) begin
                    w_nstate = S_DR_TAIL;
                    w_ncnt   = 6'd0;
                end
            end
            S_DR_TAIL: begin
                if (r_cnt == 6'd1) begin
                    w_nstate = S_FIN;
                    w_ncnt   = 6'd0;
                end
            end
            default: ;
        endcase

        w_ntms = r_tms;
        w_ntdi = 1'b0;
        case (w_nstate)
`ifdef JTAG_MASTER_TLR_EN
            S_TLR:      w_ntms = (w_ncnt != 6'd5);
`endif
            S_IR_HDR:   w_ntms = (w_ncnt < 6'd2);
            S_IR_SHIFT: begin
                w_ntms = (w_ncnt == r_ir_len - 6'd1);
                w_ntdi = w_ir_nxt[0];
            end
            S_IR_UPD:   w_ntms = 1'b1;
            S_DR_HDR:   w_ntms = (w_ncnt == 6'd0);
            S_DR_SHIFT: begin
                w_ntms = (w_ncnt == r_dr_len - 6'd1);
                w_ntdi = w_dr_nxt[0];
            end
            S_DR_TAIL:  w_ntms = (w_ncnt == 6'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_div    <= '0;
            r_ir_len <= 6'd1;
            r_dr_len <= 6'd1;
            r_ir     <= '0;
            r_dr     <= '0;
            r_cap    <= '0;
            r_dout   <= '0;
            r_tdo_s1 <= 1'b0;
            r_tdo_s2 <= 1'b0;
            r_tck    <= 1'b0;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tdo_s1 <= tdo_i;
            r_tdo_s2 <= r_tdo_s1;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        // First step of both entry sequences drives TMS=1 with TDI idle.
                        r_state  <= C_FIRST;
                        r_cnt    <= 6'd0;
                        r_div    <= '0;
                        r_tck    <= 1'b0;
                        r_tms    <= 1'b1;
                        r_tdi    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ir_len <= w_ir_len_eff;
                        r_dr_len <= w_dr_len_eff;
                        r_ir     <= ir_data_i;
                        r_dr     <= dr_data_i;
                        r_cap    <= '0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dout  <= w_cap_aligned;
                end
                default: begin
                    if (w_tick) begin
                        r_div <= '0;
                        r_tck <= ~r_tck;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                    if (w_rise && (r_state == S_DR_SHIFT)) begin
                        r_cap <= {r_tdo_s2, r_cap[MAX_LEN-1:1]};
                    end
                    if (w_fall) begin
                        r_state <= w_nstate;
                        r_cnt   <= w_ncnt;
                        r_tms   <= w_ntms;
                        r_tdi   <= w_ntdi;
                        r_ir    <= w_ir_nxt;
                        r_dr    <= w_dr_nxt;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_chain_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_chain_master
//  Purpose  : Vector table + random transactions checked against a sequence model
//             and an IEEE 1149.1 TAP state tracker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_chain_master;

`ifdef JTAG_MASTER_TLR_EN
    localparam int EXTRA = 6;
`else
    localparam int EXTRA = 0;
`endif

    localparam int T_TLR = 0, T_RTI = 1, T_SELDR = 2, T_CAPDR = 3, T_SHDR = 4, T_EX1DR = 5,
                   T_PSDR = 6, T_EX2DR = 7, T_UPDR = 8, T_SELIR = 9, T_CAPIR = 10, T_SHIR = 11,
                   T_EX1IR = 12, T_PSIR = 13, T_EX2IR = 14, T_UPIR = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  ir_len = 6'd0;
    logic [5:0]  dr_len = 6'd0;
    logic [31:0] ir_data = 32'd0;
    logic [31:0] dr_data = 32'd0;
    logic        busy, done, tck, tms, tdi, tdo;
    logic [31:0] dout;
    int          tdo_mode = 0;
    logic        tdo_dly = 1'b0;

    logic        start2 = 1'b0;
    logic        busy2, done2, tck2, tms2, tdi2;
    logic [31:0] dout2;

    always @(posedge clk) tdo_dly <= tdi;
    assign tdo = (tdo_mode == 0) ? tdo_dly : (tdo_mode == 1);

    jtag_chain_master #(.MAX_LEN(32), .TCK_DIV(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .ir_len_i(ir_len), .ir_data_i(ir_data), .dr_len_i(dr_len), .dr_data_i(dr_data),
        .busy_o(busy), .done_o(done), .dr_data_o(dout),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
    );

    jtag_chain_master #(.MAX_LEN(32), .TCK_DIV(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2),
        .ir_len_i(6'd4), .ir_data_i(32'h3), .dr_len_i(6'd3), .dr_data_i(32'h5),
        .busy_o(busy2), .done_o(done2), .dr_data_o(dout2),
        .tck_o(tck2), .tms_o(tms2), .tdi_o(tdi2), .tdo_i(1'b0)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic int tap_next(input int s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PSDR;
            T_PSDR:  return m ? T_EX2DR : T_PSDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PSIR;
            T_PSIR:  return m ? T_EX2IR : T_PSIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    function automatic logic [31:0] mask32(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    // Pin monitor and TAP tracker for the main instance, sampled at clk falling edge.
    int          rises = 0, viol = 0;
    logic        tck_q = 1'b0, tms_q = 1'b1, tdi_q = 1'b0;
    bit          q_tms[$];
    bit          q_tdi[$];
    int          tap_st = T_RTI;
    logic [63:0] ir_acc = 64'd0, ir_upd = 64'd0;
    int          ir_cnt = 0, dr_cnt = 0;
    bit          trst = 1'b0;

    always @(negedge clk) begin
        tck_q <= tck;
        tms_q <= tms;
        tdi_q <= tdi;
        if (tck && (tms !== tms_q || tdi !== tdi_q)) viol <= viol + 1;
        if (trst) begin
            tap_st <= T_RTI;
        end else if (tck && !tck_q) begin
            rises <= rises + 1;
            q_tms.push_back(tms);
            q_tdi.push_back(tdi);
            if (tap_st == T_CAPIR) begin ir_acc <= 64'd0; ir_cnt <= 0; end
            if (tap_st == T_SHIR) begin
                ir_acc <= ir_acc | (64'(tdi) << ir_cnt);
                ir_cnt <= ir_cnt + 1;
            end
            if (tap_st == T_CAPDR) dr_cnt <= 0;
            if (tap_st == T_SHDR)  dr_cnt <= dr_cnt + 1;
            if ((tap_st == T_EX1IR || tap_st == T_EX2IR) && tms) ir_upd <= ir_acc;
            tap_st <= tap_next(tap_st, tms);
        end
    end

    // Clock-shape monitor for the TCK_DIV=2 instance.
    int   rises2 = 0, bad2 = 0, viol2 = 0, hi2 = 0, cyc2 = 0, last_rise2 = -1;
    bit   done2_seen = 1'b0;
    logic tck2_q = 1'b0, tms2_q = 1'b1, tdi2_q = 1'b0;

    always @(negedge clk) begin
        cyc2   <= cyc2 + 1;
        tck2_q <= tck2;
        tms2_q <= tms2;
        tdi2_q <= tdi2;
        if (done2) done2_seen <= 1'b1;
        if (tck2 && (tms2 !== tms2_q || tdi2 !== tdi2_q)) viol2 <= viol2 + 1;
        if (tck2) hi2 <= hi2 + 1;
        else if (tck2_q) begin
            if (hi2 != 2) bad2 <= bad2 + 1;
            hi2 <= 0;
        end
        if (tck2 && !tck2_q) begin
            rises2 <= rises2 + 1;
            if (last_rise2 >= 0 && (cyc2 - last_rise2) != 4) bad2 <= bad2 + 1;
            last_rise2 <= cyc2;
        end
    end

    // Expected pin sequence built from the TAP walk rules.
    bit exp_tms[$];
    bit exp_tdi[$];

    task automatic push_step(input bit m, input bit d);
        exp_tms.push_back(m);
        exp_tdi.push_back(d);
    endtask

    task automatic build_model(input int ireff, input logic [31:0] ir, input int len, input logic [31:0] dr);
        exp_tms.delete();
        exp_tdi.delete();
        if (EXTRA > 0) begin
            repeat (5) push_step(1'b1, 1'b0);
            push_step(1'b0, 1'b0);
        end
        push_step(1'b1, 1'b0); push_step(1'b1, 1'b0); push_step(1'b0, 1'b0); push_step(1'b0, 1'b0);
        for (int k = 0; k < ireff; k++) push_step(k == ireff - 1, (k < 32) ? ir[k] : 1'b0);
        push_step(1'b1, 1'b0);
        push_step(1'b1, 1'b0); push_step(1'b0, 1'b0); push_step(1'b0, 1'b0);
        for (int k = 0; k < len; k++) push_step(k == len - 1, dr[k]);
        push_step(1'b1, 1'b0); push_step(1'b0, 1'b0);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run_txn(input int irl, input logic [31:0] ir, input int drl, input logic [31:0] dr,
                           input int mode, input logic [31:0] exp_dr, input int exp_tck, input bit poke);
        int ireff, len, base_r, base_q, nbusy, nbad_m, nbad_d, extra_done;
        bit seen;
        ireff = (irl == 0) ? 1 : irl;
        len   = (drl == 0) ? 1 : ((drl > 32) ? 32 : drl);
        build_model(ireff, ir, len, dr);
        @(negedge clk);
        ir_len   = 6'(irl);
        ir_data  = ir;
        dr_len   = 6'(drl);
        dr_data  = dr;
        tdo_mode = mode;
        start    = 1'b1;
        base_r   = rises;
        base_q   = q_tms.size();
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        seen  = 1'b0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                start = (poke && cyc == 37);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("busy_at_done", busy, 0);
        check("tck_count", rises - base_r, exp_tck);
        check("busy_cycles", nbusy, 8 * exp_tck + 1);
        check("dr_data", dout, exp_dr);
        check("seq_len", q_tms.size() - base_q, exp_tms.size());
        nbad_m = 0;
        nbad_d = 0;
        for (int k = 0; k < exp_tms.size() && base_q + k < q_tms.size(); k++) begin
            if (q_tms[base_q + k] != exp_tms[k]) nbad_m++;
            if (q_tdi[base_q + k] != exp_tdi[k]) nbad_d++;
        end
        check("tms_seq_errs", nbad_m, 0);
        check("tdi_seq_errs", nbad_d, 0);
        check("tap_end_state", tap_st, T_RTI);
        check("tap_ir_update", ir_upd, {32'd0, ir & mask32(ireff)});
        check("tap_dr_shifts", dr_cnt, len);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        if (poke) begin
            extra_done = 0;
            repeat (30) begin
                if (done) extra_done++;
                @(negedge clk);
            end
            check("single_done", extra_done, 0);
            check("idle_after_poke", busy, 0);
        end
    endtask

    typedef struct {
        int          irl;
        logic [31:0] ir;
        int          drl;
        logic [31:0] dr;
        int          mode;
        logic [31:0] exp_dr;
        int          exp_tck;
        bit          poke;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int irl, drl, mode, ireff, len, base_r;
        logic [31:0] ir, dr, expd;
        bit seen;

        #200000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int irl, drl, mode, ireff, len, base_r;
        logic [31:0] ir, dr, expd;
        bit seen;

        vecs[0] = '{8,  32'h11, 32, 32'hA5C3_0F96, 0, 32'hA5C3_0F96, 50 + EXTRA, 1'b0};
        vecs[1] = '{4,  32'h9,  1,  32'h1,         0, 32'h1,         15 + EXTRA, 1'b0};
        vecs[2] = '{4,  32'h5,  5,  32'h0,         1, 32'h1F,        19 + EXTRA, 1'b1};
        vecs[3] = '{4,  32'h5,  0,  32'h0,         1, 32'h1,         15 + EXTRA, 1'b0};
        vecs[4] = '{0,  32'h1,  40, 32'hFFFF_0000, 0, 32'hFFFF_0000, 43 + EXTRA, 1'b0};
        vecs[5] = '{6,  32'h2A, 7,  32'h55,        2, 32'h0,         23 + EXTRA, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dr_data", dout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].irl, vecs[i].ir, vecs[i].drl, vecs[i].dr, vecs[i].mode,
                    vecs[i].exp_dr, vecs[i].exp_tck, vecs[i].poke);

        check("div2_done", done2_seen, 1);
        check("div2_tck_count", rises2, 17 + EXTRA);
        check("div2_tck_shape", bad2, 0);
        check("div2_pin_stable", viol2, 0);
        check("div2_dr_data", dout2, 0);

        // start_i held high: two back-to-back transactions.
        @(negedge clk);
        ir_len = 6'd4; ir_data = 32'h3; dr_len = 6'd3; dr_data = 32'h5; tdo_mode = 2;
        start  = 1'b1;
        base_r = rises;
        @(negedge clk);
        wait_done(seen);
        check("b2b_done1", seen, 1);
        check("b2b_tck1", rises - base_r, 17 + EXTRA);
        base_r = rises;
        @(negedge clk);
        check("b2b_busy_again", busy, 1);
        wait_done(seen);
        start = 1'b0;
        check("b2b_done2", seen, 1);
        check("b2b_tck2", rises - base_r, 17 + EXTRA);
        repeat (3) @(negedge clk);
        check("b2b_stopped", busy, 0);

        // Asynchronous reset part way through a scan.
        ir_len = 6'd8; ir_data = 32'h11; dr_len = 6'd32; dr_data = 32'hA5C3_0F96; tdo_mode = 0;
        start  = 1'b1;
        base_r = rises;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && (rises - base_r) < 20; c++) @(negedge clk);
        check("rst_reached_tck20", (rises - base_r) >= 20, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tck", tck, 0);
        check("arst_tms", tms, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dr_data", dout, 0);
        trst = (EXTRA == 0);
        @(negedge clk);
        #1 trst = 1'b0;
        rst_n = 1'b1;
        run_txn(4, 32'h9, 1, 32'h1, 0, 32'h1, 15 + EXTRA, 1'b0);

        for (int i = 0; i < 16; i++) begin
            irl   = int'($urandom_range(0, 12));
            drl   = int'($urandom_range(0, 40));
            ir    = $urandom;
            dr    = $urandom;
            mode  = int'($urandom_range(0, 2));
            ireff = (irl == 0) ? 1 : irl;
            len   = (drl == 0) ? 1 : ((drl > 32) ? 32 : drl);
            expd  = (mode == 0) ? (dr & mask32(len)) : ((mode == 1) ? mask32(len) : 32'd0);
            run_txn(irl, ir, drl, dr, mode, expd, ireff + len + 10 + EXTRA, 1'b0);
        end

        check("pins_stable_tck_high", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
